// File: rtl/awb_gray_world_pipe.sv
// Gray-world auto white balance for the RGB ISP chain, placed after demosaic.
// Per-channel sums are collected over the valid pixels of frame N. A shared
// restoring divider turns them into gains G/R and G/B, and those gains are
// applied to frame N+1. Gains change only at the vsync falling edge, so a
// frame is never corrected with two different gains. A manual-gain mode
// bypasses the statistics.
module awb_gray_world_pipe #(
  parameter int DW        = 8,
  parameter int SUM_W     = 32,
  parameter int GAIN_FRAC = 8,
  parameter int GAIN_W    = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_vsync,
  input  logic              in_hsync,
  input  logic              in_den,
  input  logic [DW-1:0]     in_data_r,
  input  logic [DW-1:0]     in_data_g,
  input  logic [DW-1:0]     in_data_b,
  input  logic              mode_manual,
  input  logic [GAIN_W-1:0] man_gain_r,
  input  logic [GAIN_W-1:0] man_gain_b,
  output logic              out_vsync,
  output logic              out_hsync,
  output logic              out_den,
  output logic [DW-1:0]     out_data_r,
  output logic [DW-1:0]     out_data_g,
  output logic [DW-1:0]     out_data_b,
  output logic [GAIN_W-1:0] gain_r,
  output logic [GAIN_W-1:0] gain_b,
  output logic              gain_upd
);

  localparam int PW  = DW + GAIN_W;     // product width
  localparam int DVW = SUM_W + GAIN_W;  // wide enough for sum << GAIN_W
  localparam int CW  = (GAIN_W > 1) ? $clog2(GAIN_W) : 1;
  localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(2 ** GAIN_FRAC);
  localparam logic [GAIN_W-1:0] GAIN_MAX = '1;
  localparam logic [CW-1:0]     LAST_BIT = CW'(GAIN_W - 1);

  typedef enum logic [2:0] {IDLE, PRE, DIV_R, DIV_B, DONE} state_t;

  state_t            state, state_nx;
  logic              vs_d, vs_rise, vs_fall;
  logic [SUM_W-1:0]  sum_r, sum_g, sum_b;
  logic [SUM_W-1:0]  snap_r, snap_g, snap_b;
  logic [DVW-1:0]    dividend, rem, shifted;
  logic [SUM_W-1:0]  divisor;
  logic              r_zero, r_clamp, b_zero, b_clamp, pre_div_r, pre_div_b;
  logic              fits, do_b;
  logic [CW-1:0]     bit_cnt;
  logic [GAIN_W-1:0] q_r, q_b, pend_r, pend_b;
  logic              pending;

  logic              v1, h1, d1, v2, h2, d2;
  logic [DW-1:0]     r1, g1, b1, g2;
  logic [PW-1:0]     p_r, p_b;

  assign vs_rise = in_vsync & ~vs_d;
  assign vs_fall = ~in_vsync & vs_d;

  // Previous vsync, for edge detection on the raw input.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vs_d <= 1'b0;
    else          vs_d <= in_vsync;
  end

  // Channel accumulators; snapshot and restart at the vsync rise.
  // NOTE: the sums are reset so that a partial frame seen before or during
  // reset never leaks into the first computed gains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_r  <= '0; sum_g  <= '0; sum_b  <= '0;
      snap_r <= '0; snap_g <= '0; snap_b <= '0;
    end else if (vs_rise) begin
      snap_r <= sum_r; snap_g <= sum_g; snap_b <= sum_b;
      sum_r  <= in_den ? SUM_W'(in_data_r) : '0;
      sum_g  <= in_den ? SUM_W'(in_data_g) : '0;
      sum_b  <= in_den ? SUM_W'(in_data_b) : '0;
    end else if (in_den) begin
      sum_r <= sum_r + SUM_W'(in_data_r);
      sum_g <= sum_g + SUM_W'(in_data_g);
      sum_b <= sum_b + SUM_W'(in_data_b);
    end
  end

  // Channel classification in PRE and the shifted-divisor trial subtraction.
  assign dividend  = DVW'(snap_g) << GAIN_FRAC;
  assign r_zero    = (snap_r == '0);
  assign b_zero    = (snap_b == '0);
  assign r_clamp   = dividend >= (DVW'(snap_r) << GAIN_W);
  assign b_clamp   = dividend >= (DVW'(snap_b) << GAIN_W);
  assign pre_div_r = !r_zero && !r_clamp;
  assign pre_div_b = !b_zero && !b_clamp;
  assign divisor   = (state == DIV_R) ? snap_r : snap_b;
  assign shifted   = DVW'(divisor) << bit_cnt;
  assign fits      = rem >= shifted;

  // Divider next-state; a vsync rise in any state restarts from PRE.
  // NOTE: state_nx gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = IDLE;
      PRE:     state_nx = pre_div_r ? DIV_R : (pre_div_b ? DIV_B : DONE);
      DIV_R:   if (bit_cnt == '0) state_nx = do_b ? DIV_B : DONE;
      DIV_B:   if (bit_cnt == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (vs_rise) state_nx = PRE;
  end

  // Divider datapath: one quotient bit per cycle, MSB first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      rem     <= '0;
      bit_cnt <= '0;
      q_r     <= '0;
      q_b     <= '0;
      do_b    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        PRE: begin
          q_r     <= r_zero ? UNITY : (r_clamp ? GAIN_MAX : '0);
          q_b     <= b_zero ? UNITY : (b_clamp ? GAIN_MAX : '0);
          do_b    <= pre_div_b;
          rem     <= dividend;
          bit_cnt <= LAST_BIT;
        end
        DIV_R, DIV_B: begin
          if (fits) begin
            rem <= rem - shifted;
            if (state == DIV_R) q_r[bit_cnt] <= 1'b1;
            else                q_b[bit_cnt] <= 1'b1;
          end
          if (bit_cnt == '0) begin
            rem     <= dividend;   // fresh dividend for the B phase
            bit_cnt <= LAST_BIT;
          end else begin
            bit_cnt <= bit_cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Pending/active gains; commits happen only at the vsync fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= 1'b0;
      pend_r   <= UNITY;
      pend_b   <= UNITY;
      gain_r   <= UNITY;
      gain_b   <= UNITY;
      gain_upd <= 1'b0;
    end else begin
      gain_upd <= 1'b0;
      if (vs_fall) begin
        if (mode_manual) begin
          gain_r   <= man_gain_r;
          gain_b   <= man_gain_b;
          gain_upd <= (man_gain_r != gain_r) || (man_gain_b != gain_b);
        end else if (pending) begin
          gain_r   <= pend_r;
          gain_b   <= pend_b;
          pending  <= 1'b0;
          gain_upd <= 1'b1;
        end
      end
      // A result landing in the commit cycle waits for the next fall.
      if (state == DONE && !vs_rise) begin
        pend_r  <= q_r;
        pend_b  <= q_b;
        pending <= 1'b1;
      end
    end
  end

  // Scale by GAIN_FRAC and clip to the pixel range.
  function automatic logic [DW-1:0] sat(input logic [PW-1:0] p);
    logic [PW-1:0] o;
    o = p >> GAIN_FRAC;
    return (|o[PW-1:DW]) ? {DW{1'b1}} : o[DW-1:0];
  endfunction

  // Three-stage pixel pipeline with syncs carried in lockstep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {v1, h1, d1, v2, h2, d2} <= '0;
      {out_vsync, out_hsync, out_den} <= '0;
      {r1, g1, b1, g2} <= '0;
      p_r <= '0; p_b <= '0;
      {out_data_r, out_data_g, out_data_b} <= '0;
    end else begin
      {v1, h1, d1} <= {in_vsync, in_hsync, in_den};
      {r1, g1, b1} <= {in_data_r, in_data_g, in_data_b};
      {v2, h2, d2} <= {v1, h1, d1};
      p_r <= PW'(r1) * PW'(gain_r);
      p_b <= PW'(b1) * PW'(gain_b);
      g2  <= g1;
      {out_vsync, out_hsync, out_den} <= {v2, h2, d2};
      out_data_r <= sat(p_r);
      out_data_g <= g2;
      out_data_b <= sat(p_b);
    end
  end

endmodule

// File: tb/tb_awb_gray_world_pipe.sv
// Bench for awb_gray_world_pipe: randomized and directed frames driven
// against a frame-level reference model; expected pixels go into a
// scoreboard queue that an independent monitor drains on out_den.
module tb_awb_gray_world_pipe;

  localparam int DW = 8, SUM_W = 32, GAIN_FRAC = 8, GAIN_W = 12;
  localparam int UNITY = 256, GMAX = 4095;

  logic clk = 1'b0;
  logic reset_n;
  logic in_vsync, in_hsync, in_den;
  logic [DW-1:0] in_data_r, in_data_g, in_data_b;
  logic mode_manual;
  logic [GAIN_W-1:0] man_gain_r, man_gain_b;
  logic out_vsync, out_hsync, out_den;
  logic [DW-1:0] out_data_r, out_data_g, out_data_b;
  logic [GAIN_W-1:0] gain_r, gain_b;
  logic gain_upd;

  awb_gray_world_pipe #(.DW(DW), .SUM_W(SUM_W), .GAIN_FRAC(GAIN_FRAC), .GAIN_W(GAIN_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_vsync(in_vsync), .in_hsync(in_hsync), .in_den(in_den),
    .in_data_r(in_data_r), .in_data_g(in_data_g), .in_data_b(in_data_b),
    .mode_manual(mode_manual), .man_gain_r(man_gain_r), .man_gain_b(man_gain_b),
    .out_vsync(out_vsync), .out_hsync(out_hsync), .out_den(out_den),
    .out_data_r(out_data_r), .out_data_g(out_data_g), .out_data_b(out_data_b),
    .gain_r(gain_r), .gain_b(gain_b), .gain_upd(gain_upd)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model state (frame level).
  logic [31:0] m_sr, m_sg, m_sb;
  bit          m_prev, m_pend, m_busy;
  int          m_gr, m_gb, m_pr, m_pb, m_qr, m_qb, m_ready, m_t;
  int          upd_exp = 0, upd_seen = 0;
  logic [23:0] sb[$];

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Gain = G/X scaled by 256; unity for an empty channel, clamp on overflow.
  function automatic void ref_gain(input logic [31:0] g, input logic [31:0] x,
                                   output int q, output int divided);
    longint unsigned gg, xx;
    gg = longint'(g);
    xx = longint'(x);
    divided = 0;
    if (xx == 0)                 q = UNITY;
    else if (gg * 256 >= xx * 4096) q = GMAX;
    else begin
      q = int'((gg * 256) / xx);
      divided = 1;
    end
  endfunction

  task automatic model_reset();
    m_sr = 0; m_sg = 0; m_sb = 0;
    m_prev = 0; m_pend = 0; m_busy = 0;
    m_gr = UNITY; m_gb = UNITY; m_pr = UNITY; m_pb = UNITY;
    sb.delete();
  endtask

  // Advance the model by one cycle using the inputs currently driven.
  task automatic step();
    bit rise, fall;
    int qr, qb, dr, db;
    rise = in_vsync && !m_prev;
    fall = !in_vsync && m_prev;
    if (m_busy && m_t >= m_ready) begin
      m_pend = 1; m_pr = m_qr; m_pb = m_qb; m_busy = 0;
    end
    if (fall) begin
      if (mode_manual) begin
        if (int'(man_gain_r) != m_gr || int'(man_gain_b) != m_gb) upd_exp++;
        m_gr = int'(man_gain_r);
        m_gb = int'(man_gain_b);
      end else if (m_pend) begin
        m_gr = m_pr; m_gb = m_pb; m_pend = 0; upd_exp++;
      end
    end
    if (rise) begin
      ref_gain(m_sg, m_sr, qr, dr);
      ref_gain(m_sg, m_sb, qb, db);
      m_qr = qr; m_qb = qb; m_busy = 1;
      // stats available PRE + divided phases + DONE after the rise
      m_ready = m_t + 3 + GAIN_W * (dr + db);
      m_sr = in_den ? 32'(in_data_r) : 32'd0;
      m_sg = in_den ? 32'(in_data_g) : 32'd0;
      m_sb = in_den ? 32'(in_data_b) : 32'd0;
    end else if (in_den) begin
      m_sr = m_sr + 32'(in_data_r);
      m_sg = m_sg + 32'(in_data_g);
      m_sb = m_sb + 32'(in_data_b);
    end
    if (in_den)
      sb.push_back({8'(sat8((int'(in_data_r) * m_gr) >>> GAIN_FRAC)), in_data_g,
                    8'(sat8((int'(in_data_b) * m_gb) >>> GAIN_FRAC))});
    m_prev = in_vsync;
    m_t++;
  endtask

  task automatic drive(input bit vs, input bit hs, input bit de,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    in_vsync = vs; in_hsync = hs; in_den = de;
    in_data_r = r; in_data_g = g; in_data_b = b;
    step();
    @(posedge clk);
    #1;
  endtask

  // One frame: vsync pulse, back porch, `lines` lines of 4 pixels.
  task automatic frame(input int vs_len, input int lines, input bit rnd,
                       input logic [7:0] cr, input logic [7:0] cg, input logic [7:0] cb);
    logic [7:0] r, g, b;
    repeat (vs_len) drive(1, 0, 0, 0, 0, 0);
    repeat (4) drive(0, 0, 0, 0, 0, 0);
    check("gain_r_after_fall", 32'(gain_r), 32'(m_gr));
    check("gain_b_after_fall", 32'(gain_b), 32'(m_gb));
    for (int l = 0; l < lines; l++) begin
      drive(0, 1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      for (int p = 0; p < 4; p++) begin
        r = rnd ? 8'($urandom_range(0, 255)) : cr;
        g = rnd ? 8'($urandom_range(0, 255)) : cg;
        b = rnd ? 8'($urandom_range(0, 255)) : cb;
        drive(0, 0, 1, r, g, b);
      end
      repeat (2) drive(0, 0, 0, 0, 0, 0);
    end
    repeat (4) drive(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: syncs must equal the inputs three cycles earlier; pixels are
  // compared against the scoreboard whenever out_den is high.
  logic [2:0]  h0 = '0, h1 = '0, h2 = '0;
  logic [23:0] exp_pix;
  initial begin
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        h0 = '0; h1 = '0; h2 = '0;
      end else begin
        h2 = h1; h1 = h0; h0 = {in_vsync, in_hsync, in_den};
      end
      @(negedge clk);
      if (!reset_n) begin
        check("reset_outputs", 32'({out_vsync, out_hsync, out_den, out_data_r,
                                    out_data_g, out_data_b, gain_upd}), 32'd0);
      end else begin
        check("sync_delay3", 32'({out_vsync, out_hsync, out_den}), 32'(h2));
        if (gain_upd) upd_seen++;
        if (out_den) begin
          if (sb.size() == 0) check("unexpected_pixel", 32'(sb.size()), 32'd1);
          else begin
            exp_pix = sb.pop_front();
            check("pixel_rgb", 32'({out_data_r, out_data_g, out_data_b}), 32'(exp_pix));
          end
        end
      end
    end
  end

  int sel, vl, ln;

  initial begin
    reset_n = 1'b1;
    {in_vsync, in_hsync, in_den} = '0;
    {in_data_r, in_data_g, in_data_b} = '0;
    mode_manual = 1'b0; man_gain_r = 12'd256; man_gain_b = 12'd256;
    m_t = 0;
    model_reset();
    #1 reset_n = 1'b0;
    #1;
    check("reset_gain_r", 32'(gain_r), 32'd256);
    check("reset_gain_b", 32'(gain_b), 32'd256);
    check("reset_out", 32'({out_vsync, out_den, out_data_r, out_data_b, gain_upd}), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Neutral scene: unity gains, output equals input.
    repeat (3) frame(30, 4, 0, 100, 100, 100);
    check("t1_gain_r", 32'(gain_r), 32'd256);
    check("t1_gain_b", 32'(gain_b), 32'd256);

    // Colour cast: gains 512 / 128 applied to the following frame.
    frame(30, 4, 0, 50, 100, 200);
    frame(30, 4, 0, 50, 100, 200);
    check("t2_gain_r", 32'(gain_r), 32'd512);
    check("t2_gain_b", 32'(gain_b), 32'd128);

    // Gain clamp and output saturation.
    frame(30, 4, 0, 1, 255, 100);
    frame(30, 4, 0, 255, 255, 100);
    check("t3_gain_r_clamp", 32'(gain_r), 32'd4095);

    // Empty red channel falls back to unity; blue still divided.
    frame(30, 4, 0, 0, 100, 50);
    frame(30, 4, 0, 0, 100, 50);
    check("t4_gain_r_unity", 32'(gain_r), 32'd256);
    check("t4_gain_b", 32'(gain_b), 32'd512);

    // Manual gain takes effect only at the next vsync fall.
    mode_manual = 1'b1; man_gain_r = 12'd384; man_gain_b = 12'd256;
    drive(0, 0, 0, 0, 0, 0);
    check("t5_gain_r_held", 32'(gain_r), 32'd256);
    frame(30, 4, 0, 100, 100, 100);
    check("t5_gain_r_manual", 32'(gain_r), 32'd384);
    mode_manual = 1'b0;
    frame(30, 4, 0, 100, 100, 100);

    // Reset in the middle of a division.
    repeat (6) drive(1, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    in_vsync = 1'b0;
    #1;
    check("t6_reset_gain_r", 32'(gain_r), 32'd256);
    check("t6_reset_out", 32'({out_vsync, out_hsync, out_den, out_data_r,
                               out_data_g, out_data_b}), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    frame(30, 4, 0, 50, 100, 200);
    frame(10, 4, 0, 50, 100, 200);
    check("t6_commit_deferred", 32'(gain_r), 32'd256);
    frame(30, 4, 0, 50, 100, 200);
    check("t6_commit_next", 32'(gain_r), 32'd512);

    // Randomized frames: random pixels, pulse widths, blank frames, manual.
    for (int i = 0; i < 16; i++) begin
      sel = int'($urandom_range(0, 5));
      mode_manual = ($urandom_range(0, 3) == 0);
      man_gain_r = 12'($urandom_range(0, 1023));
      man_gain_b = 12'($urandom_range(0, 1023));
      vl = (sel == 0) ? int'($urandom_range(3, 26)) : 30;
      ln = 4;
      if (sel == 1) begin vl = 3; ln = 0; end
      frame(vl, ln, 1, 0, 0, 0);
    end
    mode_manual = 1'b0;
    repeat (2) frame(30, 4, 1, 0, 0, 0);

    repeat (8) drive(0, 0, 0, 0, 0, 0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("gain_upd_count", 32'(upd_seen), 32'(upd_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
